prod_stock_ctrl: RTL and testbench
==================================

// Module: prod_stock_ctrl
// PURPOSE
//  Owns per-slot product stock counts and serialises buyer dispense / admin restock requests.
//  Two requesters share one count-update datapath through an alternating-priority arbiter.
//  Drives prod_count_current (count of the currently selected slot) into prod_based_led.
//  Sits between the coin/selection FSM and the LED indicator.
// PARAMETERS
//  N_PROD    4  number of product slots (sel width SEL_W = $clog2(N_PROD))
//  CNT_W     4  stock counter width
//  MAX_CNT   9  saturation ceiling for restock
//  INIT_CNT  5  per-slot count loaded at reset
// PORTS
//  clk                 in   1      clock, rising edge
//  rst                 in   1      reset, asynchronous, active-low
//  sel_prod            in   SEL_W  slot currently selected by user/admin
//  dispense_req        in   1      level; held until dispense_ack or dispense_nak
//  restock_req         in   1      level; held until restock_ack or restock_nak
//  restock_amt         in   CNT_W  units to add; sampled at grant
//  dispense_ack        out  1      1-cycle pulse: one unit removed
//  dispense_nak        out  1      1-cycle pulse: slot empty or sel_prod invalid
//  restock_ack         out  1      1-cycle pulse: restock applied (possibly saturated)
//  restock_nak         out  1      1-cycle pulse: sel_prod invalid
//  restock_sat         out  1      valid with restock_ack: result clipped to MAX_CNT
//  busy                out  1      high in any state other than IDLE
//  prod_count_current  out  CNT_W  registered count of slot sel_prod; 0 if sel_prod invalid
//  stock_empty         out  N_PROD bit i = (count[i] == 0), registered
// BEHAVIOUR
//  Reset: all counts = INIT_CNT; all pulses, restock_sat, busy = 0; FSM = IDLE; prio = dispense;
//   prod_count_current = 0 until first clk edge after release; stock_empty = 0.
//  FSM: IDLE -> GRANT -> EXEC -> RESP -> RELEASE -> IDLE.
//   IDLE:    any req high -> GRANT; latch sel_prod, restock_amt, granted op.
//   GRANT:   validity/empty check on latched slot; result registered.
//   EXEC:    count write: dispense count-1; restock min(count+amt, MAX_CNT) (CNT_W+1-bit sum).
//   RESP:    exactly one of the four pulses asserted, 1 cycle; restock_sat alongside ack.
//   RELEASE: wait until granted req low -> IDLE (no re-grant on a held req).
//  Latency: req seen high in IDLE at edge n -> pulse high in cycle n+3.
//  Arbitration: both reqs high in IDLE -> grant side = prio; prio toggles after each
//   simultaneous-conflict grant only; single req always granted.
//  Dispense on count 0 or sel_prod >= N_PROD -> nak, counts unchanged.
//  Restock amt 0 -> ack, count unchanged, sat 0. Invalid slot -> restock_nak, no write.
//  sel_prod / restock_amt changes after grant ignored until next grant.
//  prod_count_current/stock_empty: 1-cycle registered view; reflect EXEC write in RESP cycle.
//  Reset mid-operation: abort, no pulse, counts reload INIT_CNT.
// STRUCTURE
//  prod_pkg: N_PROD, CNT_W, MAX_CNT defaults, FSM state encoding (IDLE..RELEASE), op enum.
//  Sub-module prod_rr_arb: 2-input alternating-priority arbiter (req_d, req_r -> gnt, prio reg).
//  Count array, FSM, output regs in this module.
// TESTING
//  Reset, sel_prod=2 -> prod_count_current=5 after 1 clk; stock_empty=0000.
//  Dispense slot 1 x5 -> five acks, count 0, stock_empty[1]=1; 6th -> dispense_nak.
//  Restock slot 0 amt 7 from 5 -> restock_ack+restock_sat, count 9; amt 0 -> ack, sat 0.
//  Both reqs same cycle twice -> dispense first, then restock; next conflict dispense again.
//  Dispense with sel_prod=4 (N_PROD=4 via SEL_W=3 override) -> nak; req held -> single pulse.
//  rst low in EXEC -> no pulse, all counts 5, busy 0; pulse n+3 timing checked on every op.

Source files
------------

// File: rtl/prod_pkg.sv
// Shared defaults and encodings for the product stock controller.
// States follow one request from grant through response and release.
package prod_pkg;

    localparam int N_PROD_DEF   = 4;
    localparam int CNT_W_DEF    = 4;
    localparam int MAX_CNT_DEF  = 9;
    localparam int INIT_CNT_DEF = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        EXEC    = 3'd2,
        RESP    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    typedef enum logic {
        OP_DISP = 1'b0,
        OP_RST  = 1'b1
    } op_t;

endpackage

// File: rtl/prod_rr_arb.sv
// Two-input arbiter between dispense and restock.
// Priority flips only when both requests compete in the same grant cycle.
module prod_rr_arb
    import prod_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_d,
    input  logic req_r,
    input  logic take,
    output op_t  gnt,
    output logic gnt_vld
);

    logic prio;

    always_comb begin
        gnt_vld = req_d | req_r;
        gnt     = OP_DISP;
        if (req_d && req_r) begin
            gnt = prio ? OP_RST : OP_DISP;
        end else if (req_r) begin
            gnt = OP_RST;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio <= 1'b0;
        end else if (take && req_d && req_r) begin
            prio <= ~prio;
        end
    end

endmodule

// File: rtl/prod_stock_ctrl.sv
// Per-slot stock counters with a serialised dispense/restock update path.
// One request at a time walks IDLE -> GRANT -> EXEC -> RESP -> RELEASE.
module prod_stock_ctrl
    import prod_pkg::*;
#(
    parameter int N_PROD   = N_PROD_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_CNT  = MAX_CNT_DEF,
    parameter int INIT_CNT = INIT_CNT_DEF,
    parameter int SEL_W    = $clog2(N_PROD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sel_prod,
    input  logic              dispense_req,
    input  logic              restock_req,
    input  logic [CNT_W-1:0]  restock_amt,
    output logic              dispense_ack,
    output logic              dispense_nak,
    output logic              restock_ack,
    output logic              restock_nak,
    output logic              restock_sat,
    output logic              busy,
    output logic [CNT_W-1:0]  prod_count_current,
    output logic [N_PROD-1:0] stock_empty
);

    state_t             state, state_nx;
    op_t                op_r, gnt;
    logic               gnt_vld, take;
    logic [SEL_W-1:0]   slot_r;
    logic [CNT_W-1:0]   amt_r;
    logic               ok_r, sat_r;
    logic [CNT_W-1:0]   cnt    [N_PROD];
    logic [CNT_W-1:0]   cnt_nx [N_PROD];
    logic [CNT_W-1:0]   cur, view, dec, rs_val;
    logic [CNT_W:0]     sum;
    logic               slot_ok, sel_ok, sat;

    assign take = (state == IDLE);

    prod_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_d   (dispense_req),
        .req_r   (restock_req),
        .take    (take),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    // Update datapath on the latched slot; the sum is one bit wider so saturation sees the carry.
    always_comb begin
        slot_ok = (32'(slot_r) < N_PROD);
        sel_ok  = (32'(sel_prod) < N_PROD);
        cur     = '0;
        view    = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (32'(slot_r) == i) cur = cnt[i];
        end
        dec    = cur - CNT_W'(1);
        sum    = {1'b0, cur} + {1'b0, amt_r};
        sat    = (sum > (CNT_W+1)'(MAX_CNT));
        rs_val = sat ? CNT_W'(MAX_CNT) : sum[CNT_W-1:0];
        for (int i = 0; i < N_PROD; i++) begin
            cnt_nx[i] = cnt[i];
            if (state == EXEC && ok_r && 32'(slot_r) == i) begin
                cnt_nx[i] = (op_r == OP_DISP) ? dec : rs_val;
            end
        end
        for (int i = 0; i < N_PROD; i++) begin
            if (32'(sel_prod) == i) view = cnt_nx[i];
        end
    end

    // Stage boundary: counts and the registered status view both load from cnt_nx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PROD; i++) cnt[i] <= CNT_W'(INIT_CNT);
            prod_count_current <= '0;
            stock_empty        <= '0;
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                cnt[i]         <= cnt_nx[i];
                stock_empty[i] <= (cnt_nx[i] == '0);
            end
            prod_count_current <= sel_ok ? view : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && gnt_vld) begin
            slot_r <= sel_prod;
            amt_r  <= restock_amt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            op_r  <= OP_DISP;
            ok_r  <= 1'b0;
            sat_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt_vld) op_r <= gnt;
            if (state == GRANT) ok_r <= slot_ok && (op_r == OP_RST || cur != '0);
            if (state == EXEC)  sat_r <= sat;
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = (state != IDLE);
        dispense_ack = 1'b0;
        dispense_nak = 1'b0;
        restock_ack  = 1'b0;
        restock_nak  = 1'b0;
        restock_sat  = 1'b0;
        case (state)
            IDLE:    if (gnt_vld) state_nx = GRANT;
            GRANT:   state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP: begin
                state_nx = RELEASE;
                if (op_r == OP_DISP) begin
                    dispense_ack = ok_r;
                    dispense_nak = ~ok_r;
                end else begin
                    restock_ack = ok_r;
                    restock_nak = ~ok_r;
                    restock_sat = ok_r & sat_r;
                end
            end
            RELEASE: begin
                // Wait for the served requester to drop so a held level is not re-granted.
                if (op_r == OP_DISP ? !dispense_req : !restock_req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prod_stock_ctrl.sv
// Directed bench for prod_stock_ctrl with hand-computed expectations.
// Built with SEL_W=3 so out-of-range slot selects can be driven.
module tb_prod_stock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel_prod;
    logic       dispense_req, restock_req;
    logic [3:0] restock_amt;
    logic       dispense_ack, dispense_nak, restock_ack, restock_nak, restock_sat, busy;
    logic [3:0] prod_count_current;
    logic [3:0] stock_empty;
    logic [4:0] pv;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_DACK = 5'b10000;
    localparam logic [4:0] P_DNAK = 5'b01000;
    localparam logic [4:0] P_RACK = 5'b00100;
    localparam logic [4:0] P_RNAK = 5'b00010;
    localparam logic [4:0] P_RSAT = 5'b00101;

    prod_stock_ctrl #(.SEL_W(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .sel_prod           (sel_prod),
        .dispense_req       (dispense_req),
        .restock_req        (restock_req),
        .restock_amt        (restock_amt),
        .dispense_ack       (dispense_ack),
        .dispense_nak       (dispense_nak),
        .restock_ack        (restock_ack),
        .restock_nak        (restock_nak),
        .restock_sat        (restock_sat),
        .busy               (busy),
        .prod_count_current (prod_count_current),
        .stock_empty        (stock_empty)
    );

    assign pv = {dispense_ack, dispense_nak, restock_ack, restock_nak, restock_sat};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Request raised just after an edge; first edge seen in IDLE is n, pulse expected after edge n+2.
    task automatic do_op(input string tag, input bit d, input bit r, input logic [2:0] sel,
                         input logic [3:0] amt, input int hold,
                         input logic [4:0] exp_p, input logic [3:0] exp_cnt);
        sel_prod     = sel;
        restock_amt  = amt;
        dispense_req = d;
        restock_req  = r;
        @(posedge clk); #1;
        restock_amt = 4'hF;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_p1"}, 32'(pv), 32'(P_NONE));
        @(posedge clk); #1;
        chk({tag, "_p2"}, 32'(pv), 32'(P_NONE));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(pv), 32'(exp_p));
        chk({tag, "_cnt"}, 32'(prod_count_current), 32'(exp_cnt));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_hold%0d", tag, k), {31'd0, busy} + 32'(pv), 32'd1);
        end
        dispense_req = 1'b0;
        restock_req  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        sel_prod     = 3'd2;
        dispense_req = 1'b0;
        restock_req  = 1'b0;
        restock_amt  = 4'd0;
        #12;
        chk("rst_cnt", 32'(prod_count_current), 32'd0);
        chk("rst_empty", 32'(stock_empty), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulse", 32'(pv), 32'(P_NONE));
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_view", 32'(prod_count_current), 32'd5);
        chk("rst_empty2", 32'(stock_empty), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_op($sformatf("disp1_%0d", i), 1, 0, 3'd1, 4'd0, 0, P_DACK, 4'(4 - i));
        end
        chk("empty_s1", 32'(stock_empty), 32'b0010);
        do_op("disp1_empty", 1, 0, 3'd1, 4'd0, 0, P_DNAK, 4'd0);

        do_op("rst0_sat", 0, 1, 3'd0, 4'd7, 0, P_RSAT, 4'd9);
        do_op("rst0_zero", 0, 1, 3'd0, 4'd0, 0, P_RACK, 4'd9);
        do_op("rst3_add", 0, 1, 3'd3, 4'd2, 0, P_RACK, 4'd7);
        do_op("rst3_back", 1, 0, 3'd3, 4'd0, 0, P_DACK, 4'd6);

        do_op("conf1", 1, 1, 3'd2, 4'd1, 0, P_DACK, 4'd4);
        do_op("conf2", 1, 1, 3'd2, 4'd1, 0, P_RACK, 4'd5);
        do_op("conf3", 1, 1, 3'd2, 4'd1, 0, P_DACK, 4'd4);

        do_op("disp_inv", 1, 0, 3'd4, 4'd0, 4, P_DNAK, 4'd0);
        do_op("rst_inv", 0, 1, 3'd5, 4'd3, 0, P_RNAK, 4'd0);
        sel_prod = 3'd0;
        @(posedge clk); #1;
        chk("s0_after_inv", 32'(prod_count_current), 32'd9);

        sel_prod     = 3'd3;
        dispense_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_pulse", 32'(pv), 32'(P_NONE));
        dispense_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel_prod = 3'(s);
            @(posedge clk); #1;
            chk($sformatf("mid_cnt%0d", s), 32'(prod_count_current), 32'd5);
            chk($sformatf("mid_np%0d", s), {31'd0, busy} + 32'(pv), 32'd0);
        end
        chk("mid_empty", 32'(stock_empty), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
